// File: rtl/clk_enable_nco.sv
// Multi-channel fractional clock-enable generator: one phase accumulator per channel,
// gated by a synchronised PLL lock and a delayed downstream reset, with HALT/STEP control.

module clk_enable_nco_ch #(
  parameter int unsigned            ACC_WIDTH   = 24,
  parameter logic [ACC_WIDTH-1:0]   DEFAULT_INC = '0
) (
  input  logic                 clk_cpu_fast,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [ACC_WIDTH-1:0] inc_in,
  input  logic                 clr,
  input  logic                 adv,
  input  logic                 hold,
  input  logic                 step,
  output logic                 ce
);
  logic [ACC_WIDTH-1:0] acc, inc;
  logic [ACC_WIDTH:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, inc};

  always_ff @(posedge clk_cpu_fast or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      inc <= DEFAULT_INC;
      ce  <= 1'b0;
    end else begin
      // increment loads independently of lock so configuration survives a lock loss
      if (load) inc <= inc_in;
      if (clr) begin
        acc <= '0;
        ce  <= 1'b0;
      end else if (adv) begin
        {ce, acc} <= sum;
      end else if (hold) begin
        ce <= step;
      end else begin
        ce <= 1'b0;
      end
    end
  end
endmodule

module clk_enable_nco #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned ACC_WIDTH   = 24,
  parameter int unsigned DEFAULT_INC = 599186,
  parameter int unsigned RESET_DELAY = 16,
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic                           clk_cpu_fast,
  input  logic                           rst_n,
  input  logic                           pll_locked,
  input  logic [NUM_CH*ACC_WIDTH-1:0]    cfg_inc,
  input  logic                           cfg_load,
  input  logic                           halt,
  input  logic                           step,
  output logic [NUM_CH-1:0]              ce,
  output logic                           rst_sync_n,
  output logic [1:0]                     state
);
  localparam int CNT_W = $clog2(RESET_DELAY + 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'b00,
    DELAY     = 2'b01,
    RUN       = 2'b10,
    HALT      = 2'b11
  } state_t;

  state_t                         cur, nxt;
  logic [SYNC_STAGES-1:0]         sync_q;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           lock_s;
  logic                           clr, adv, hold;
  logic [NUM_CH-1:0][ACC_WIDTH-1:0] inc_lane;

  assign lock_s   = sync_q[SYNC_STAGES-1];
  assign inc_lane = cfg_inc;
  assign state    = cur;

  always_ff @(posedge clk_cpu_fast or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  always_ff @(posedge clk_cpu_fast or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= WAIT_LOCK;
      cnt_q      <= '0;
      rst_sync_n <= 1'b0;
    end else begin
      cur        <= nxt;
      cnt_q      <= cnt_d;
      rst_sync_n <= (nxt == RUN) || (nxt == HALT);
    end
  end

  // lock loss overrides every state
  always_comb begin
    nxt   = cur;
    cnt_d = cnt_q;
    if (!lock_s) begin
      nxt   = WAIT_LOCK;
      cnt_d = '0;
    end else begin
      case (cur)
        WAIT_LOCK: begin
          nxt   = DELAY;
          cnt_d = '0;
        end
        DELAY: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(RESET_DELAY - 1)) nxt = halt ? HALT : RUN;
        end
        RUN:     if (halt)  nxt = HALT;
        HALT:    if (!halt) nxt = RUN;
        default: nxt = WAIT_LOCK;
      endcase
    end
  end

  assign clr  = !lock_s;
  assign adv  = lock_s && (cur == RUN);
  assign hold = lock_s && (cur == HALT);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_enable_nco_ch #(
      .ACC_WIDTH  (ACC_WIDTH),
      .DEFAULT_INC(ACC_WIDTH'(DEFAULT_INC))
    ) u_ch (
      .clk_cpu_fast(clk_cpu_fast),
      .rst_n       (rst_n),
      .load        (cfg_load),
      .inc_in      (inc_lane[i]),
      .clr         (clr),
      .adv         (adv),
      .hold        (hold),
      .step        (step),
      .ce          (ce[i])
    );
  end
endmodule

// File: tb/tb_clk_enable_nco.sv
// Directed bench for clk_enable_nco: a default-width instance and an 8-bit accumulator instance
// share all control inputs; each step checks hand-computed values with immediate assertions.

module tb_clk_enable_nco;
  logic        clk = 1'b0;
  logic        rst_n, pll_locked, cfg_load, halt, step;
  logic [47:0] inc24;
  logic [15:0] inc8;
  logic [1:0]  ce24, ce8, st24, st8;
  logic        rsn24, rsn8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  clk_enable_nco dut (
    .clk_cpu_fast(clk), .rst_n(rst_n), .pll_locked(pll_locked), .cfg_inc(inc24),
    .cfg_load(cfg_load), .halt(halt), .step(step), .ce(ce24), .rst_sync_n(rsn24), .state(st24)
  );

  clk_enable_nco #(.ACC_WIDTH(8), .DEFAULT_INC(32)) dut8 (
    .clk_cpu_fast(clk), .rst_n(rst_n), .pll_locked(pll_locked), .cfg_inc(inc8),
    .cfg_load(cfg_load), .halt(halt), .step(step), .ce(ce8), .rst_sync_n(rsn8), .state(st8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic lock_seq(input string tag);
    for (int e = 1; e <= 20; e++) begin
      tick();
      chk({tag, "_rsn"},  32'(rsn24), (e >= 20) ? 1 : 0);
      chk({tag, "_rsn8"}, 32'(rsn8),  (e >= 20) ? 1 : 0);
      chk({tag, "_state"}, 32'(st8), (e <= 3) ? 0 : (e <= 19) ? 1 : 2);
    end
  endtask

  initial begin
    int n0, n1, adj, m0, m1;
    logic p0;
    rst_n = 1'b0; pll_locked = 1'b0; cfg_load = 1'b0; halt = 1'b0; step = 1'b0;
    inc24 = {2{24'd599186}};
    inc8  = {8'd64, 8'd64};
    repeat (3) tick();
    chk("rst_state", 32'(st24), 0);
    chk("rst_rsn",   32'(rsn24), 0);
    chk("rst_ce",    32'(ce24), 0);
    chk("rst_ce8",   32'(ce8), 0);

    // load increments while still waiting for lock
    rst_n = 1'b1; tick();
    cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    tick();
    chk("wait_state", 32'(st24), 0);

    // T1 power-up sequence
    pll_locked = 1'b1;
    lock_seq("t1");

    // T2 (8-bit, inc 64) and T3 (defaults, 28000 RUN cycles)
    n0 = 0; n1 = 0; adj = 0; p0 = 1'b0;
    for (int r = 1; r <= 28000; r++) begin
      tick();
      if (ce24[0]) n0++;
      if (ce24[1]) n1++;
      if (ce24[0] && p0) adj++;
      p0 = ce24[0];
      if (r <= 16) chk("t2_ce8", 32'(ce8), (r % 4 == 0) ? 3 : 0);
    end
    chk("t3_count_ch0", n0, 999);
    chk("t3_count_ch1", n1, 999);
    chk("t3_adjacent", adj, 0);

    // T4 halt mid-RUN, three steps spaced 5 cycles
    halt = 1'b1; tick();
    chk("t4_state_halt", 32'(st8), 3);
    chk("t4_entry_ce8", 32'(ce8), 0);
    for (int k = 0; k < 3; k++) begin
      step = 1'b1; tick(); step = 1'b0;
      chk("t4_step_ce8",  32'(ce8), 3);
      chk("t4_step_ce24", 32'(ce24), 3);
      for (int j = 0; j < 4; j++) begin
        tick();
        chk("t4_idle_ce8",  32'(ce8), 0);
        chk("t4_idle_ce24", 32'(ce24), 0);
      end
    end
    chk("t4_still_halt", 32'(st8), 3);
    halt = 1'b0; tick();
    chk("t4_exit_state", 32'(st8), 2);
    chk("t4_exit_ce8", 32'(ce8), 0);
    tick(); chk("t4_phase1", 32'(ce8), 0);
    tick(); chk("t4_phase2", 32'(ce8), 0);
    tick(); chk("t4_phase3", 32'(ce8), 3);
    step = 1'b1; tick(); step = 1'b0;
    chk("t4_step_in_run", 32'(ce8), 0);
    tick(); tick(); tick();
    chk("t5_pre_carry", 32'(ce8), 3);

    // T5 lock loss; edge 4 would carry and also carries a cfg_load (T6)
    pll_locked = 1'b0;
    repeat (3) tick();
    inc8 = {8'd255, 8'd0};
    cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    chk("t5_rsn",    32'(rsn24), 0);
    chk("t5_rsn8",   32'(rsn8), 0);
    chk("t5_state",  32'(st24), 0);
    chk("t5_state8", 32'(st8), 0);
    chk("t5_ce8",    32'(ce8), 0);
    chk("t5_ce24",   32'(ce24), 0);
    tick(); tick();
    chk("t5_wait", 32'(st8), 0);
    pll_locked = 1'b1;
    lock_seq("t5_relock");

    // T6 ch0 inc=0, ch1 inc=255
    m0 = 0; m1 = 0;
    for (int r = 1; r <= 512; r++) begin
      tick();
      if (ce8[0]) m0++;
      if (ce8[1]) m1++;
      chk("t6_ce8", 32'(ce8), ((r - 1) % 256 != 0) ? 2 : 0);
    end
    chk("t6_count_ch0", m0, 0);
    chk("t6_count_ch1", m1, 510);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
